// File: rtl/letter_select.sv
// Push-button letter selector: steps a one-hot / binary letter number 1..26 with
// wrap-around, hold-to-auto-repeat and a parallel load port.
module letter_select #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_next_n,
    input  logic        key_prev_n,
    input  logic        load,
    input  logic [4:0]  load_idx,
    output logic [25:0] val,
    output logic [4:0]  idx,
    output logic        step
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic [1:0]    nxt_sync, prv_sync;
    logic          nxt_s, prv_s, nxt, prv;
    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          dir, dir_d;          // 0 = next, 1 = prev
    logic          blocked;             // set by a two-key press, cleared once both are up
    logic          go_step, go_prev;
    logic          held_alone, load_ok;

    assign nxt_s = nxt_sync[1];
    assign prv_s = prv_sync[1];
    assign nxt   = ~nxt_s;
    assign prv   = ~prv_s;

    assign held_alone = dir ? (prv && !nxt) : (nxt && !prv);
    assign load_ok    = load && (load_idx >= 5'd1) && (load_idx <= 5'd26);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dir_d   = dir;
        go_step = 1'b0;
        go_prev = dir;
        case (state)
            IDLE: begin
                if ((nxt ^ prv) && !blocked) begin
                    go_step = 1'b1;
                    go_prev = prv;
                    dir_d   = prv;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!held_alone) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    go_step = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!held_alone) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                    go_step = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nxt_sync <= 2'b11;
            prv_sync <= 2'b11;
            val      <= 26'd1;
            idx      <= 5'd1;
            step     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            dir      <= 1'b0;
            blocked  <= 1'b0;
        end else begin
            nxt_sync <= {nxt_sync[0], key_next_n};
            prv_sync <= {prv_sync[0], key_prev_n};

            if (nxt && prv)
                blocked <= 1'b1;
            else if (!nxt && !prv)
                blocked <= 1'b0;

            // A valid load wins over any key step and restarts the key FSM.
            if (load_ok) begin
                val   <= 26'd1 << (load_idx - 5'd1);
                idx   <= load_idx;
                step  <= 1'b1;
                state <= IDLE;
                cnt   <= '0;
                dir   <= dir_d;
            end else begin
                state <= state_d;
                cnt   <= cnt_d;
                dir   <= dir_d;
                step  <= go_step;
                if (go_step) begin
                    if (go_prev) begin
                        val <= {val[0], val[25:1]};
                        idx <= (idx == 5'd1) ? 5'd26 : idx - 5'd1;
                    end else begin
                        val <= {val[24:0], val[25]};
                        idx <= (idx == 5'd26) ? 5'd1 : idx + 5'd1;
                    end
                end
            end
        end
    end

endmodule
